// File: rtl/player_control_if.sv
// Key inputs and datapath control outputs of the player-sprite controller.
// master: the side that presses keys and watches the strobes.
// slave: the controller itself.
interface player_control_if;
    logic       move_left;
    logic       move_right;
    logic       ld_1;
    logic       ld_2;
    logic       ld_3;
    logic       ld_4;
    logic       erase;
    logic       draw;
    logic       plot;
    logic [1:0] lane;
    logic       busy;

    modport master (
        output move_left, move_right,
        input  ld_1, ld_2, ld_3, ld_4, erase, draw, plot, lane, busy
    );

    modport slave (
        input  move_left, move_right,
        output ld_1, ld_2, ld_3, ld_4, erase, draw, plot, lane, busy
    );
endinterface

// File: rtl/player_control.sv
// Player-sprite control FSM: turns left/right key edges into lane moves across
// four lanes, sequencing erase of the old sprite, lane load and redraw.
module player_control #(
    parameter int unsigned DRAW_CYCLES = 16
) (
    input logic             clock,
    input logic             reset,
    player_control_if.slave bus
);
    localparam int unsigned CntW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DRAW_CYCLES - 1);

    typedef enum logic [2:0] {StStart, StIdle, StErase, StLoad, StDraw} state_e;

    state_e          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      target_q, target_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            left_q, right_q;

    logic            left_req, right_req;
    logic            ld_en;
    logic [1:0]      ld_sel;
    logic [3:0]      ld_vec;
    logic            erase, draw, plot;

    // Rising edge of the raw key against its value one cycle earlier.
    assign left_req  = bus.move_left & ~left_q;
    assign right_req = bus.move_right & ~right_q;

    // State, lane, target, phase counter and key history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StStart;
            lane_q   <= 2'd0;
            target_q <= 2'd0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            // Edge history keeps tracking while busy so a held key never retriggers.
            left_q   <= bus.move_left;
            right_q  <= bus.move_right;
        end
    end

    // Next-state logic; the counter defaults to zero so it clears on every state entry.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        target_d = target_q;
        cnt_d    = '0;
        unique case (state_q)
            StStart: begin
                target_d = 2'd0;
                state_d  = StLoad;
            end
            StIdle: begin
                // Simultaneous edges and moves off either end are discarded.
                if (left_req && !right_req && lane_q != 2'd0) begin
                    target_d = lane_q - 2'd1;
                    state_d  = StErase;
                end else if (right_req && !left_req && lane_q != 2'd3) begin
                    target_d = lane_q + 2'd1;
                    state_d  = StErase;
                end
            end
            StErase: begin
                if (cnt_q == CntLast) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoad: begin
                lane_d  = target_q;
                state_d = StDraw;
            end
            StDraw: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StStart;
        endcase
    end

    // Moore output decode; erase and draw address the committed lane, load the target.
    always_comb begin
        ld_en  = 1'b0;
        ld_sel = lane_q;
        erase  = 1'b0;
        draw   = 1'b0;
        plot   = 1'b0;
        unique case (state_q)
            StErase: begin
                ld_en = 1'b1;
                erase = 1'b1;
                plot  = 1'b1;
            end
            StLoad: begin
                ld_en  = 1'b1;
                ld_sel = target_q;
            end
            StDraw: begin
                ld_en = 1'b1;
                draw  = 1'b1;
                plot  = 1'b1;
            end
            default: ld_en = 1'b0;
        endcase
        ld_vec = ld_en ? (4'b0001 << ld_sel) : 4'b0000;
    end

    assign bus.ld_1  = ld_vec[0];
    assign bus.ld_2  = ld_vec[1];
    assign bus.ld_3  = ld_vec[2];
    assign bus.ld_4  = ld_vec[3];
    assign bus.erase = erase;
    assign bus.draw  = draw;
    assign bus.plot  = plot;
    assign bus.lane  = lane_q;
    assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_player_control.sv
// Bench for player_control: three instances (DRAW_CYCLES 16, 4, 1) checked each
// cycle against a timeline model of the move sequence.
module tb_player_control;
    logic       clk = 1'b0;
    logic       rst [3];
    logic       ml  [3];
    logic       mr  [3];
    logic [9:0] obs [3];  // {ld_4..ld_1, erase, draw, plot, lane[1:0], busy}

    int dcyc [3] = '{16, 4, 1};
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    player_control_if if0 ();
    player_control_if if1 ();
    player_control_if if2 ();

    player_control #(.DRAW_CYCLES(16)) u_dut0 (.clock(clk), .reset(rst[0]), .bus(if0.slave));
    player_control #(.DRAW_CYCLES(4))  u_dut1 (.clock(clk), .reset(rst[1]), .bus(if1.slave));
    player_control #(.DRAW_CYCLES(1))  u_dut2 (.clock(clk), .reset(rst[2]), .bus(if2.slave));

    assign if0.move_left  = ml[0];
    assign if0.move_right = mr[0];
    assign if1.move_left  = ml[1];
    assign if1.move_right = mr[1];
    assign if2.move_left  = ml[2];
    assign if2.move_right = mr[2];
    assign obs[0] = {if0.ld_4, if0.ld_3, if0.ld_2, if0.ld_1, if0.erase, if0.draw, if0.plot,
                     if0.lane, if0.busy};
    assign obs[1] = {if1.ld_4, if1.ld_3, if1.ld_2, if1.ld_1, if1.erase, if1.draw, if1.plot,
                     if1.lane, if1.busy};
    assign obs[2] = {if2.ld_4, if2.ld_3, if2.ld_2, if2.ld_1, if2.erase, if2.draw, if2.plot,
                     if2.lane, if2.busy};

    // Timeline model: seq 0 = idle, 1 = boot (after reset), 2 = move.
    // k counts cycles since the sequence began.
    bit m_rst  [3];
    int m_seq  [3];
    int m_k    [3];
    int m_lane [3];
    int m_old  [3];
    int m_new  [3];
    bit m_pl   [3];
    bit m_pr   [3];

    function automatic logic [3:0] onehot(int l);
        logic [3:0] v;
        v = 4'b0001;
        return v << l;
    endfunction

    function automatic logic [9:0] exp_out(int i);
        logic [3:0] ld;
        logic       er, dr, pl, bz;
        logic [1:0] ln;
        int         d, k;
        ld = 4'b0000; er = 1'b0; dr = 1'b0; pl = 1'b0; bz = 1'b1;
        ln = 2'(m_lane[i]);
        d  = dcyc[i];
        k  = m_k[i];
        if (m_rst[i]) begin
            ln = 2'd0;
        end else if (m_seq[i] == 0) begin
            bz = 1'b0;
        end else if (m_seq[i] == 1) begin
            if (k == 1) ld = onehot(0);
            else if (k >= 2) begin ld = onehot(0); dr = 1'b1; pl = 1'b1; end
        end else begin
            if (k <= d) begin ld = onehot(m_old[i]); er = 1'b1; pl = 1'b1; end
            else if (k == d + 1) ld = onehot(m_new[i]);
            else begin ld = onehot(m_new[i]); dr = 1'b1; pl = 1'b1; end
        end
        return {ld, er, dr, pl, ln, bz};
    endfunction

    function automatic void model_reset(int i);
        m_rst[i] = 1'b1; m_seq[i] = 1; m_k[i] = 0; m_lane[i] = 0;
        m_pl[i] = 1'b0; m_pr[i] = 1'b0;
    endfunction

    function automatic void model_tick(int i);
        bit le, re;
        int d;
        if (m_rst[i]) return;
        d  = dcyc[i];
        le = ml[i] && !m_pl[i];
        re = mr[i] && !m_pr[i];
        if (m_seq[i] == 0) begin
            if (le && !re && m_lane[i] > 0) begin
                m_seq[i] = 2; m_k[i] = 1; m_old[i] = m_lane[i]; m_new[i] = m_lane[i] - 1;
            end else if (re && !le && m_lane[i] < 3) begin
                m_seq[i] = 2; m_k[i] = 1; m_old[i] = m_lane[i]; m_new[i] = m_lane[i] + 1;
            end
        end else if (m_seq[i] == 1) begin
            m_k[i]++;
            if (m_k[i] == d + 2) m_seq[i] = 0;
        end else begin
            m_k[i]++;
            if (m_k[i] == d + 2) m_lane[i] = m_new[i];
            if (m_k[i] == 2 * d + 2) m_seq[i] = 0;
        end
        m_pl[i] = ml[i];
        m_pr[i] = mr[i];
    endfunction

    // Stimulus plumbing only: advance one clock, keeping the model in step.
    task automatic tick_all();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_tick(i);
        @(negedge clk);
    endtask

    task automatic settle(int i);
        int g = 0;
        while (m_seq[i] != 0 && g < 500) begin
            tick_all();
            g++;
        end
    endtask

    task automatic pulse(int i, logic l, logic r);
        ml[i] = l; mr[i] = r;
        tick_all();
        ml[i] = 1'b0; mr[i] = 1'b0;
    endtask

    task automatic test_reset();
        int busy_at = -1;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; ml[i] = 1'b0; mr[i] = 1'b0;
            model_reset(i);
        end
        for (int c = 0; c < 3; c++) begin
            tick_all();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== 10'b0000_000_00_1) begin
                    n_errors++;
                    $display("FAIL reset_hold inst%0d: got %b want %b", i, obs[i],
                             10'b0000_000_00_1);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            m_rst[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== exp_out(i)) begin
                n_errors++;
                $display("FAIL reset_start inst%0d: got %b want %b", i, obs[i], exp_out(i));
            end
        end
        for (int c = 1; c <= 20; c++) begin
            tick_all();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_out(i)) begin
                    n_errors++;
                    $display("FAIL reset_boot inst%0d cyc%0d: got %b want %b", i, c, obs[i],
                             exp_out(i));
                end
            end
            if (busy_at < 0 && obs[0][0] === 1'b0) busy_at = c;
        end
        n_checks++;
        if (busy_at != 18) begin
            n_errors++;
            $display("FAIL reset_busy_fall: got cycle %0d want 18", busy_at);
        end
    endtask

    task automatic test_right_move();
        int lat = 1;
        mr[0] = 1'b1;
        tick_all();
        mr[0] = 1'b0;
        while (obs[0][0] === 1'b1 && lat < 100) begin
            n_checks++;
            if (obs[0] !== exp_out(0)) begin
                n_errors++;
                $display("FAIL right_move cyc%0d: got %b want %b", lat, obs[0], exp_out(0));
            end
            tick_all();
            lat++;
        end
        n_checks++;
        if (lat != 34) begin
            n_errors++;
            $display("FAIL right_move_latency: got %0d want 34", lat);
        end
        n_checks++;
        if (obs[0][2:1] !== 2'd1) begin
            n_errors++;
            $display("FAIL right_move_lane: got %0d want 1", obs[0][2:1]);
        end
    endtask

    task automatic test_boundary();
        pulse(0, 1'b1, 1'b0);
        settle(0);
        pulse(0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick_all();
            n_checks++;
            if (obs[0][2:0] !== 3'b000) begin
                n_errors++;
                $display("FAIL left_at_lane0: got lane %0d busy %b want lane 0 busy 0",
                         obs[0][2:1], obs[0][0]);
            end
        end
        for (int n = 0; n < 3; n++) begin
            pulse(0, 1'b0, 1'b1);
            settle(0);
        end
        pulse(0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick_all();
            n_checks++;
            if (obs[0][2:0] !== 3'b110) begin
                n_errors++;
                $display("FAIL right_at_lane3: got lane %0d busy %b want lane 3 busy 0",
                         obs[0][2:1], obs[0][0]);
            end
        end
    endtask

    task automatic test_simul_and_held();
        pulse(0, 1'b1, 1'b0);
        settle(0);
        pulse(0, 1'b1, 1'b0);
        settle(0);
        pulse(0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick_all();
            n_checks++;
            if (obs[0][2:0] !== 3'b010) begin
                n_errors++;
                $display("FAIL simultaneous: got lane %0d busy %b want lane 1 busy 0",
                         obs[0][2:1], obs[0][0]);
            end
        end
        mr[0] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick_all();
            n_checks++;
            if (obs[0] !== exp_out(0)) begin
                n_errors++;
                $display("FAIL held_key cyc%0d: got %b want %b", c, obs[0], exp_out(0));
            end
        end
        mr[0] = 1'b0;
        settle(0);
        n_checks++;
        if (obs[0][2:0] !== 3'b100) begin
            n_errors++;
            $display("FAIL held_key_lane: got lane %0d busy %b want lane 2 busy 0",
                     obs[0][2:1], obs[0][0]);
        end
    endtask

    task automatic test_drop_while_busy();
        pulse(0, 1'b1, 1'b0);
        settle(0);
        pulse(0, 1'b0, 1'b1);
        tick_all();
        tick_all();
        pulse(0, 1'b1, 1'b0);
        settle(0);
        for (int c = 0; c < 5; c++) begin
            tick_all();
            n_checks++;
            if (obs[0] !== 10'b0000_000_10_0) begin
                n_errors++;
                $display("FAIL drop_while_busy: got %b want %b", obs[0], 10'b0000_000_10_0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        pulse(1, 1'b0, 1'b1);
        while (m_k[1] < 7 && g < 50) begin
            tick_all();
            g++;
        end
        n_checks++;
        if (obs[1] !== exp_out(1) || obs[1][4] !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_draw: got %b want %b", obs[1], exp_out(1));
        end
        #2;
        rst[1] = 1'b1;
        model_reset(1);
        #1;
        n_checks++;
        if (obs[1] !== 10'b0000_000_00_1) begin
            n_errors++;
            $display("FAIL async_reset: got %b want %b", obs[1], 10'b0000_000_00_1);
        end
        tick_all();
        tick_all();
        rst[1] = 1'b0;
        m_rst[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick_all();
            n_checks++;
            if (obs[1] !== exp_out(1)) begin
                n_errors++;
                $display("FAIL restart cyc%0d: got %b want %b", c, obs[1], exp_out(1));
            end
        end
        n_checks++;
        if (obs[1] !== 10'b0000_000_00_0) begin
            n_errors++;
            $display("FAIL restart_lane0: got %b want %b", obs[1], 10'b0000_000_00_0);
        end
    endtask

    task automatic test_single_cycle();
        int lat = 1;
        mr[2] = 1'b1;
        tick_all();
        mr[2] = 1'b0;
        while (obs[2][0] === 1'b1 && lat < 20) begin
            n_checks++;
            if (obs[2] !== exp_out(2)) begin
                n_errors++;
                $display("FAIL single_cycle cyc%0d: got %b want %b", lat, obs[2], exp_out(2));
            end
            tick_all();
            lat++;
        end
        n_checks++;
        if (lat != 4 || obs[2][2:1] !== 2'd1) begin
            n_errors++;
            $display("FAIL single_cycle_latency: got %0d lane %0d want 4 lane 1", lat,
                     obs[2][2:1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) ml[i] = ~ml[i];
                if ($urandom_range(0, 3) == 0) mr[i] = ~mr[i];
            end
            tick_all();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_out(i)) begin
                    n_errors++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", i, c, obs[i],
                             exp_out(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_right_move();
        test_boundary();
        test_simul_and_held();
        test_drop_while_busy();
        test_reset_mid();
        test_single_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
